// File: rtl/universal_shift_reg.sv
// WIDTH-bit storage register: parallel load/clear plus multi-step shift, rotate and
// arithmetic shift (one bit per clock) under a start/busy/done handshake. Optional abort: USR_ABORT_EN.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
`ifdef USR_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_ASHR = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;
  logic             abort_w;

`ifdef USR_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // The first step happens on the start edge itself, so IDLE steps with the live mode.
  always_comb begin
    step_mode = (state_q == S_RUN) ? mode_q : mode;
    step_q    = q_q;
    step_sout = sout_q;
    case (step_mode)
      M_SHL:  begin step_q = {q_q[WIDTH-2:0], sin};        step_sout = q_q[WIDTH-1]; end
      M_SHR:  begin step_q = {sin, q_q[WIDTH-1:1]};        step_sout = q_q[0];       end
      M_ROTL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sout = q_q[WIDTH-1]; end
      M_ROTR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};     step_sout = q_q[0];       end
      M_ASHR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_sout = q_q[0];     end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mode)
            M_HOLD: done_d = 1'b1;
            M_LOAD: begin
              q_d    = din;
              done_d = 1'b1;
            end
            M_CLR: begin
              q_d    = '0;
              sout_d = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              if (amt == '0) begin
                done_d = 1'b1;
              end else begin
                q_d    = step_q;
                sout_d = step_sout;
                mode_d = mode;
                cnt_d  = amt - AMT_W'(1);
                if (amt == AMT_W'(1)) done_d  = 1'b1;
                else                  state_d = S_RUN;
              end
            end
          endcase
        end
      end
      default: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          q_d    = step_q;
          sout_d = step_sout;
          cnt_d  = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;

endmodule
